spi_cmd_sequencer: RTL and testbench

// - Transaction controller behind the SPI byte slave: converts its per-byte strobes into register-bus reads/writes.
// - Frame = 1 command byte {rw, addr[6:0]} + N data bytes, with an auto-incrementing address; ss high ends the frame.
// - Prefetches read data so tx_byte is valid before the slave loads its next byte.
// - Sits between the SPI byte slave and the on-chip register file / peripheral bus.

---
 rtl/spi_ctrl_pkg.sv | 24 ++
 rtl/spi_bus_watchdog.sv | 50 +++++
 rtl/spi_cmd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared definitions for the SPI command sequencer:
//   - state_t      : 3-bit FSM state encodings S_IDLE..S_RDATA
//   - CMD_RW_BIT   : bit of the command byte selecting read (1) / write (0)
//   - CMD_ADDR_MSB : top bit of the address field in the command byte
//   - FILL_BYTE_DEF: byte shifted out when no valid read data is available
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CMD    = 3'd1,
      S_WDATA  = 3'd2,
      S_WBUS   = 3'd3,
      S_RFETCH = 3'd4,
      S_RDATA  = 3'd5
   } state_t;

   localparam int         CMD_RW_BIT    = 7;
   localparam int         CMD_ADDR_MSB  = 6;
   localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/spi_bus_watchdog.sv
// -----------------------------------------------------------------------------
// spi_bus_watchdog
// Bounds how long a bus master waits for an acknowledge. The counter runs
// while a request is pending and restarts on ack. expire pulses in the
// TIMEOUT-th cycle of a pending request so the master's registered clear
// drops the request exactly TIMEOUT cycles after it was raised.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   req    in  a bus request is outstanding
//   ack    in  bus completion this cycle (wins over expire)
//   expire out one-cycle pulse: request has been pending for TIMEOUT cycles
// -----------------------------------------------------------------------------
module spi_bus_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic ack,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   assign expire = req && !ack && (cnt_r == CNT_W'(TIMEOUT - 1));

   // Next count: restart whenever the request ends, completes or expires.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (!req || ack || expire) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end
   end

   // Pending-cycle counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
// Turns the byte strobes of an SPI byte slave into register-bus transfers.
// A frame (ss low) is one command byte {rw, addr} followed by data bytes with
// an auto-incrementing address. Read data is prefetched so tx_byte is ready
// before the slave loads its next byte slot.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ss                    slave select (synchronized), 0 = frame active
//   rx_strobe, rx_byte    received byte and its one-cycle strobe
//   tx_strobe, tx_byte    slave latches tx_byte on tx_strobe
//   bus_addr, bus_wdata   register bus address / write data
//   bus_we, bus_re        write / read request, held until ack or timeout
//   bus_ack, bus_rdata    one-cycle completion with read data
//   busy                  FSM is not idle
//   err_overrun           sticky: write byte arrived while the bus was busy
//   err_timeout           sticky: a bus request timed out
// -----------------------------------------------------------------------------
module spi_cmd_sequencer
   import spi_ctrl_pkg::*;
#(
   parameter int         ADDR_W    = 7,
   parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF,
   parameter bit         AUTO_INC  = 1'b1,
   parameter int         TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ss,
   input  logic              rx_strobe,
   input  logic [7:0]        rx_byte,
   input  logic              tx_strobe,
   output logic [7:0]        tx_byte,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   output logic              bus_we,
   output logic              bus_re,
   input  logic              bus_ack,
   input  logic [7:0]        bus_rdata,
   output logic              busy,
   output logic              err_overrun,
   output logic              err_timeout
);

   state_t            state_r, state_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [7:0]        wdata_r, wdata_nxt_s;
   logic [7:0]        tx_r, tx_nxt_s;
   logic              we_r, we_nxt_s;
   logic              re_r, re_nxt_s;
   logic              err_ovr_r, err_ovr_nxt_s;
   logic              err_to_r, err_to_nxt_s;
   logic              underrun_r, underrun_nxt_s;  // current fetch's data is stale
   logic              abort_r, abort_nxt_s;        // ss rose while a request was pending
   logic              busy_r;

   logic              req_s;
   logic              expire_s;
   logic              done_s;
   logic [7:0]        rdata_s;
   logic [CMD_ADDR_MSB:0] cmd_addr_s;

   // Address step after each data byte; width truncation gives the wrap.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      if (AUTO_INC) begin
         r = a + ADDR_W'(1);
      end else begin
         r = a;
      end
      return r;
   endfunction

   spi_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_s),
      .ack    (bus_ack),
      .expire (expire_s)
   );

   assign req_s      = we_r | re_r;
   // A timeout completes the request exactly like an ack carrying FILL_BYTE.
   assign done_s     = req_s && (bus_ack || expire_s);
   assign rdata_s    = bus_ack ? bus_rdata : FILL_BYTE;
   assign cmd_addr_s = rx_byte[CMD_ADDR_MSB:0];

   // Next-state and next-output logic for the frame FSM.
   always_comb begin
      state_nxt_s    = state_r;
      addr_nxt_s     = addr_r;
      wdata_nxt_s    = wdata_r;
      tx_nxt_s       = tx_r;
      we_nxt_s       = we_r;
      re_nxt_s       = re_r;
      err_ovr_nxt_s  = err_ovr_r;
      err_to_nxt_s   = err_to_r;
      underrun_nxt_s = underrun_r;
      abort_nxt_s    = abort_r;

      case (state_r)
         S_IDLE: begin
            tx_nxt_s       = FILL_BYTE;
            underrun_nxt_s = 1'b0;
            abort_nxt_s    = 1'b0;
            if (!ss) begin
               state_nxt_s   = S_CMD;
               err_ovr_nxt_s = 1'b0;
               err_to_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end

         S_CMD: begin
            if (ss) begin
               state_nxt_s = S_IDLE;
            end else if (rx_strobe) begin
               addr_nxt_s = cmd_addr_s[ADDR_W-1:0];
               if (rx_byte[CMD_RW_BIT]) begin
                  re_nxt_s    = 1'b1;
                  state_nxt_s = S_RFETCH;
               end else begin
                  state_nxt_s = S_WDATA;
               end
            end else begin
               state_nxt_s = S_CMD;
            end
         end

         S_WDATA: begin
            if (ss) begin
               state_nxt_s = S_IDLE;
            end else if (rx_strobe) begin
               wdata_nxt_s = rx_byte;
               we_nxt_s    = 1'b1;
               state_nxt_s = S_WBUS;
            end else begin
               state_nxt_s = S_WDATA;
            end
         end

         S_WBUS: begin
            if (ss) begin
               abort_nxt_s = 1'b1;
            end else begin
               abort_nxt_s = abort_r;
            end
            // Only one write can be in flight; a byte arriving now is lost.
            if (rx_strobe) begin
               err_ovr_nxt_s = 1'b1;
            end else begin
               err_ovr_nxt_s = err_ovr_r;
            end
            if (done_s) begin
               we_nxt_s   = 1'b0;
               addr_nxt_s = next_addr(addr_r);
               if (expire_s) begin
                  err_to_nxt_s = 1'b1;
               end else begin
                  err_to_nxt_s = err_to_r;
               end
               if (ss || abort_r) begin
                  state_nxt_s = S_IDLE;
               end else begin
                  state_nxt_s = S_WDATA;
               end
            end else begin
               state_nxt_s = S_WBUS;
            end
         end

         S_RFETCH: begin
            tx_nxt_s = FILL_BYTE;
            if (ss) begin
               abort_nxt_s = 1'b1;
            end else begin
               abort_nxt_s = abort_r;
            end
            // Slave already took FILL_BYTE for this slot: the fetch in
            // progress belongs to a byte that has been skipped.
            if (tx_strobe) begin
               underrun_nxt_s = 1'b1;
            end else begin
               underrun_nxt_s = underrun_r;
            end
            if (done_s) begin
               re_nxt_s = 1'b0;
               if (expire_s) begin
                  err_to_nxt_s = 1'b1;
               end else begin
                  err_to_nxt_s = err_to_r;
               end
               if (ss || abort_r) begin
                  state_nxt_s = S_IDLE;
               end else if (underrun_r || tx_strobe) begin
                  // Discard and refetch the following address after a
                  // one-cycle gap so every request is a separate pulse.
                  addr_nxt_s     = next_addr(addr_r);
                  underrun_nxt_s = 1'b0;
                  state_nxt_s    = S_RFETCH;
               end else begin
                  tx_nxt_s    = rdata_s;
                  state_nxt_s = S_RDATA;
               end
            end else if (!req_s) begin
               // Gap cycle after a discarded fetch: issue the refetch.
               if (ss || abort_r) begin
                  state_nxt_s = S_IDLE;
               end else begin
                  re_nxt_s    = 1'b1;
                  state_nxt_s = S_RFETCH;
               end
            end else begin
               state_nxt_s = S_RFETCH;
            end
         end

         S_RDATA: begin
            if (ss) begin
               tx_nxt_s    = FILL_BYTE;
               state_nxt_s = S_IDLE;
            end else if (tx_strobe) begin
               tx_nxt_s    = FILL_BYTE;
               addr_nxt_s  = next_addr(addr_r);
               re_nxt_s    = 1'b1;
               state_nxt_s = S_RFETCH;
            end else begin
               state_nxt_s = S_RDATA;
            end
         end

         default: begin
            state_nxt_s = S_IDLE;
            we_nxt_s    = 1'b0;
            re_nxt_s    = 1'b0;
            tx_nxt_s    = FILL_BYTE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         addr_r     <= '0;
         wdata_r    <= 8'h00;
         tx_r       <= FILL_BYTE;
         we_r       <= 1'b0;
         re_r       <= 1'b0;
         err_ovr_r  <= 1'b0;
         err_to_r   <= 1'b0;
         underrun_r <= 1'b0;
         abort_r    <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         addr_r     <= addr_nxt_s;
         wdata_r    <= wdata_nxt_s;
         tx_r       <= tx_nxt_s;
         we_r       <= we_nxt_s;
         re_r       <= re_nxt_s;
         err_ovr_r  <= err_ovr_nxt_s;
         err_to_r   <= err_to_nxt_s;
         underrun_r <= underrun_nxt_s;
         abort_r    <= abort_nxt_s;
         busy_r     <= (state_nxt_s != S_IDLE);
      end
   end

   assign tx_byte     = tx_r;
   assign bus_addr    = addr_r;
   assign bus_wdata   = wdata_r;
   assign bus_we      = we_r;
   assign bus_re      = re_r;
   assign busy        = busy_r;
   assign err_overrun = err_ovr_r;
   assign err_timeout = err_to_r;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
// Two instances share all inputs: dut_a uses default parameters, dut_b uses
// TIMEOUT=30 for the long-ack overrun case. sel_b selects which instance's
// outputs the checks look at.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, ss, rx_strobe, tx_strobe, bus_ack;
   logic [7:0] rx_byte, bus_rdata;

   logic [7:0] tx_a, wdata_a, tx_b, wdata_b;
   logic [6:0] addr_a, addr_b;
   logic       we_a, re_a, busy_a, ovr_a, to_a;
   logic       we_b, re_b, busy_b, ovr_b, to_b;

   logic       sel_b;
   logic [7:0] tx_m, wdata_m;
   logic [6:0] addr_m;
   logic       we_m, re_m, busy_m, ovr_m, to_m;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_cmd_sequencer dut_a (
      .clk(clk), .rst_n(rst_n), .ss(ss),
      .rx_strobe(rx_strobe), .rx_byte(rx_byte),
      .tx_strobe(tx_strobe), .tx_byte(tx_a),
      .bus_addr(addr_a), .bus_wdata(wdata_a), .bus_we(we_a), .bus_re(re_a),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .busy(busy_a), .err_overrun(ovr_a), .err_timeout(to_a)
   );

   spi_cmd_sequencer #(.TIMEOUT(30)) dut_b (
      .clk(clk), .rst_n(rst_n), .ss(ss),
      .rx_strobe(rx_strobe), .rx_byte(rx_byte),
      .tx_strobe(tx_strobe), .tx_byte(tx_b),
      .bus_addr(addr_b), .bus_wdata(wdata_b), .bus_we(we_b), .bus_re(re_b),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .busy(busy_b), .err_overrun(ovr_b), .err_timeout(to_b)
   );

   assign tx_m    = sel_b ? tx_b    : tx_a;
   assign wdata_m = sel_b ? wdata_b : wdata_a;
   assign addr_m  = sel_b ? addr_b  : addr_a;
   assign we_m    = sel_b ? we_b    : we_a;
   assign re_m    = sel_b ? re_b    : re_a;
   assign busy_m  = sel_b ? busy_b  : busy_a;
   assign ovr_m   = sel_b ? ovr_b   : ovr_a;
   assign to_m    = sel_b ? to_b    : to_a;

   typedef struct {
      logic [7:0] cmd;       // command byte
      logic [7:0] data;      // write data, or read data returned by the bus
      logic [6:0] exp_addr;  // expected bus address
      logic [7:0] exp_val;   // expected bus_wdata (write) or tx_byte (read)
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte   = b;
      rx_strobe = 1'b1;
      @(negedge clk);
      rx_strobe = 1'b0;
   endtask

   task automatic send_tx(output logic [7:0] got);
      got       = tx_m;
      tx_strobe = 1'b1;
      @(negedge clk);
      tx_strobe = 1'b0;
   endtask

   task automatic ack_pulse(input logic [7:0] rd);
      bus_rdata = rd;
      bus_ack   = 1'b1;
      @(negedge clk);
      bus_ack   = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int k = 0;
      while (!(we_m || re_m) && k < 40) begin
         tick();
         k++;
      end
      check(name, 32'(we_m | re_m), 32'd1);
   endtask

   // Raise ss, ack whatever is outstanding, and require a return to idle.
   task automatic end_frame(input string name);
      ss = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (!busy_m) break;
         if ((we_m || re_m) && !bus_ack) bus_ack = 1'b1;
         else bus_ack = 1'b0;
         bus_rdata = 8'h00;
         @(negedge clk);
      end
      bus_ack = 1'b0;
      check(name, 32'(busy_m), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, got hang, expected $finish");
      $fatal(1, "tb timeout");
   end

   initial begin
      logic [7:0] got;
      logic [7:0] wb_data [3];
      logic [6:0] wb_addr [3];
      int         hi;

      vecs[0] = '{cmd: 8'h12, data: 8'h3C, exp_addr: 7'h12, exp_val: 8'h3C};
      vecs[1] = '{cmd: 8'h7E, data: 8'h00, exp_addr: 7'h7E, exp_val: 8'h00};
      vecs[2] = '{cmd: 8'h81, data: 8'hA5, exp_addr: 7'h01, exp_val: 8'hA5};
      vecs[3] = '{cmd: 8'hFF, data: 8'h5A, exp_addr: 7'h7F, exp_val: 8'h5A};
      vecs[4] = '{cmd: 8'h00, data: 8'hFF, exp_addr: 7'h00, exp_val: 8'hFF};
      wb_data = '{8'hA1, 8'hA2, 8'hA3};
      wb_addr = '{7'h05, 7'h06, 7'h07};

      rst_n = 1'b0; ss = 1'b1; rx_strobe = 1'b0; tx_strobe = 1'b0;
      rx_byte = 8'h00; bus_ack = 1'b0; bus_rdata = 8'h00; sel_b = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst tx_byte", 32'(tx_m), 32'hFF);
      check("rst bus_addr", 32'(addr_m), 32'h00);
      check("rst bus_wdata", 32'(wdata_m), 32'h00);
      check("rst bus_we", 32'(we_m), 32'd0);
      check("rst bus_re", 32'(re_m), 32'd0);
      check("rst busy", 32'(busy_m), 32'd0);
      check("rst err_overrun", 32'(ovr_m), 32'd0);
      check("rst err_timeout", 32'(to_m), 32'd0);

      // Strobes outside a frame are ignored
      send_rx(8'h05);
      tick();
      check("idle rx busy", 32'(busy_m), 32'd0);
      check("idle rx we", 32'(we_m), 32'd0);

      // Table: single-byte frames
      for (int i = 0; i < 5; i++) begin
         ss = 1'b0;
         tick();
         check("tbl busy", 32'(busy_m), 32'd1);
         send_rx(vecs[i].cmd);
         if (!vecs[i].cmd[7]) send_rx(vecs[i].data);
         wait_req("tbl req");
         check("tbl addr", 32'(addr_m), 32'(vecs[i].exp_addr));
         check("tbl we", 32'(we_m), 32'(!vecs[i].cmd[7]));
         check("tbl re", 32'(re_m), 32'(vecs[i].cmd[7]));
         if (!vecs[i].cmd[7]) check("tbl wdata", 32'(wdata_m), 32'(vecs[i].exp_val));
         tick();
         ack_pulse(vecs[i].data);
         if (vecs[i].cmd[7]) begin
            check("tbl re drop", 32'(re_m), 32'd0);
            send_tx(got);
            check("tbl tx", 32'(got), 32'(vecs[i].exp_val));
         end else begin
            check("tbl we drop", 32'(we_m), 32'd0);
         end
         end_frame("tbl end");
      end

      // Write burst: (05,A1),(06,A2),(07,A3)
      ss = 1'b0;
      tick();
      send_rx(8'h05);
      for (int i = 0; i < 3; i++) begin
         send_rx(wb_data[i]);
         check("wb we", 32'(we_m), 32'd1);
         check("wb addr", 32'(addr_m), 32'(wb_addr[i]));
         check("wb wdata", 32'(wdata_m), 32'(wb_data[i]));
         tick();
         ack_pulse(8'h00);
         check("wb we drop", 32'(we_m), 32'd0);
      end
      check("wb err_overrun", 32'(ovr_m), 32'd0);
      check("wb err_timeout", 32'(to_m), 32'd0);
      end_frame("wb end");

      // Read burst: cmd 0x90, rdata = addr ^ 0x55 -> 0x45, 0x44
      ss = 1'b0;
      tick();
      send_rx(8'h90);
      check("rb re", 32'(re_m), 32'd1);
      check("rb addr0", 32'(addr_m), 32'h10);
      ack_pulse({1'b0, addr_m} ^ 8'h55);
      send_tx(got);
      check("rb tx0", 32'(got), 32'h45);
      check("rb re again", 32'(re_m), 32'd1);
      check("rb addr1", 32'(addr_m), 32'h11);
      check("rb tx fill", 32'(tx_m), 32'hFF);
      ack_pulse({1'b0, addr_m} ^ 8'h55);
      send_tx(got);
      check("rb tx1", 32'(got), 32'h44);
      check("rb err_timeout", 32'(to_m), 32'd0);
      end_frame("rb end");

      // Address wrap 0x7F -> 0x00
      ss = 1'b0;
      tick();
      send_rx(8'h7F);
      send_rx(8'hD0);
      check("wrap addr0", 32'(addr_m), 32'h7F);
      ack_pulse(8'h00);
      send_rx(8'hD1);
      check("wrap addr1", 32'(addr_m), 32'h00);
      check("wrap wdata1", 32'(wdata_m), 32'hD1);
      ack_pulse(8'h00);
      end_frame("wrap end");

      // Read underrun: tx_strobe during the first fetch
      ss = 1'b0;
      tick();
      send_rx(8'h88);
      check("ur re", 32'(re_m), 32'd1);
      send_tx(got);
      check("ur tx fill", 32'(got), 32'hFF);
      ack_pulse(8'h11);
      check("ur re gap", 32'(re_m), 32'd0);
      check("ur addr next", 32'(addr_m), 32'h09);
      check("ur tx discard", 32'(tx_m), 32'hFF);
      tick();
      check("ur refetch", 32'(re_m), 32'd1);
      ack_pulse(8'h22);
      send_tx(got);
      check("ur tx data", 32'(got), 32'h22);
      end_frame("ur end");

      // Read timeout: bus_re high for exactly 15 cycles
      ss = 1'b0;
      tick();
      send_rx(8'h83);
      hi = 0;
      for (int k = 0; k < 20; k++) begin
         if (re_m) hi++;
         tick();
      end
      check("to re cycles", 32'(hi), 32'd15);
      check("to err_timeout", 32'(to_m), 32'd1);
      check("to re low", 32'(re_m), 32'd0);
      send_tx(got);
      check("to tx fill", 32'(got), 32'hFF);
      end_frame("to end");

      // Abort during S_WBUS, then a new frame clears errors
      ss = 1'b0;
      tick();
      check("ab err_timeout clr", 32'(to_m), 32'd0);
      send_rx(8'h30);
      send_rx(8'h77);
      check("ab we", 32'(we_m), 32'd1);
      send_rx(8'h78);
      check("ab overrun", 32'(ovr_m), 32'd1);
      check("ab wdata kept", 32'(wdata_m), 32'h77);
      ss = 1'b1;
      tick();
      tick();
      check("ab we held", 32'(we_m), 32'd1);
      check("ab busy held", 32'(busy_m), 32'd1);
      ack_pulse(8'h00);
      check("ab we drop", 32'(we_m), 32'd0);
      check("ab idle", 32'(busy_m), 32'd0);
      ss = 1'b0;
      tick();
      check("ab new busy", 32'(busy_m), 32'd1);
      check("ab overrun clr", 32'(ovr_m), 32'd0);
      send_rx(8'h40);
      send_rx(8'h99);
      check("ab new we", 32'(we_m), 32'd1);
      check("ab new addr", 32'(addr_m), 32'h40);
      check("ab new wdata", 32'(wdata_m), 32'h99);
      ack_pulse(8'h00);
      end_frame("ab end");

      // Overrun on the TIMEOUT=30 instance, ack held ~20 cycles
      ss = 1'b1;
      repeat (40) tick();
      sel_b = 1'b1;
      check("ov start idle", 32'(busy_m), 32'd0);
      ss = 1'b0;
      tick();
      send_rx(8'h20);
      send_rx(8'h11);
      check("ov we", 32'(we_m), 32'd1);
      check("ov addr", 32'(addr_m), 32'h20);
      repeat (4) tick();
      send_rx(8'h22);
      check("ov err_overrun", 32'(ovr_m), 32'd1);
      check("ov we held", 32'(we_m), 32'd1);
      check("ov wdata kept", 32'(wdata_m), 32'h11);
      repeat (13) tick();
      check("ov we before ack", 32'(we_m), 32'd1);
      ack_pulse(8'h00);
      check("ov we drop", 32'(we_m), 32'd0);
      check("ov addr next", 32'(addr_m), 32'h21);
      check("ov err sticky", 32'(ovr_m), 32'd1);
      check("ov no timeout", 32'(to_m), 32'd0);
      tick();
      tick();
      check("ov byte dropped", 32'(we_m), 32'd0);
      end_frame("ov end");
      sel_b = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
